mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the multicycle RV32I core's memory port.
//  Services one mem_read/mem_write request at a time from a word-organised
//  backing store, after a fixed latency, and pulses mem_resp on completion.
//  Sits between the core (the initiator driving MAR, MDR and the data-out
//  register) and the testbench/top level.
//  Used as the simulation memory model and as the FPGA scratch RAM.
// PARAMETERS
//  ADDR_WIDTH  10  word-index bits; store = 2**ADDR_WIDTH 32-bit words (4 KiB at default)
//  LATENCY     3   cycles from request sample to mem_resp high; legal range 1..15
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   asynchronous, active-high reset
//  mem_read         in   1   read request; held by initiator until mem_resp
//  mem_write        in   1   write request; held by initiator until mem_resp
//  mem_byte_enable  in   4   write byte lanes; bit i -> mem_wdata[8i+7:8i]
//  mem_address      in   32  byte address; word index = mem_address[ADDR_WIDTH+1:2]
//  mem_wdata        in   32  write data
//  mem_rdata        out  32  read data; valid in the mem_resp cycle of a read
//  mem_resp         out  1   one-cycle completion pulse
//  mem_error        out  1   present only with MEM_RESP_ERROR_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset: state=IDLE, mem_resp=0, mem_rdata=32'h0, mem_error=0, counter=0.
//    Storage contents are not reset.
//  - FSM states: IDLE, BUSY, RESP.
//  - IDLE: sample requests on each edge.
//    - mem_read|mem_write high: latch address, wdata, byte_enable and op.
//    - Go to BUSY with counter=LATENCY-1; if LATENCY==1, go directly to RESP.
//  - Read and write both high: treated as a write; the read is dropped.
//  - BUSY: counter decrements each cycle; moves to RESP when the counter reaches 1.
//  - RESP: mem_resp=1 for exactly one cycle, then IDLE unconditionally.
//  - Latency: mem_resp is high LATENCY cycles after the sampling edge.
//  - Inputs are ignored in BUSY and RESP: the latched copy is used.
//    Request drop or change mid-transaction does not abort it.
//  - Read: mem_rdata is loaded with store[idx] on the edge entering RESP.
//    It holds that value until the next read completes.
//    mem_byte_enable is ignored for reads; the full word is returned.
//  - Write: enabled lanes of store[idx] are updated on the edge entering RESP.
//    A following read returns the new data. byte_enable=0000 is a no-op write
//    that still responds. mem_rdata is unchanged by writes.
//  - Back-to-back: at least one IDLE cycle follows every RESP.
//    A request still high in that IDLE cycle is a new transaction.
//  - Address: mem_address[1:0] are ignored (word-aligned access).
//    Bits above ADDR_WIDTH+1 are ignored, so the store aliases/wraps.
//  - Reset mid-transaction: return to IDLE immediately and drop the pending
//    write (store untouched); mem_resp=0 and mem_rdata=0.
// CONFIGURATION
//  MEM_RESP_ERROR_EN defined:
//  - Adds the mem_error port.
//  - A request is in error if mem_address[1:0]!=0, or if any address bit
//    above ADDR_WIDTH+1 is set.
//  - An errored request still completes with normal latency.
//  - mem_error=1 alongside mem_resp; the write is suppressed; mem_rdata=32'hDEAD_BEEF.
//  MEM_RESP_ERROR_EN undefined:
//  - No mem_error port; no checks; the aliasing rules above apply.
// TESTING
//  1. LATENCY=3: write 32'h1234_5678, be=1111, addr 0x40.
//     -> mem_resp high exactly 3 cycles after the sample.
//     Then read 0x40 -> mem_rdata=32'h1234_5678 with resp.
//  2. Write 32'hAABB_CCDD, be=0010, to 0x40 (after test 1); read 0x40 -> 32'h1234_CC78.
//  3. ADDR_WIDTH=10: write 32'hCAFE_F00D to 0x1000; read 0x0 -> 32'hCAFE_F00D (alias).
//  4. mem_read and mem_write high together, wdata=32'h1, addr 0x8.
//     -> one write response; subsequent read of 0x8 -> 32'h1.
//  5. Assert rst for 1 cycle in BUSY of a write of 32'hFFFF_FFFF to 0x40.
//     -> mem_resp never pulses; read 0x40 -> old data; mem_rdata=0 after reset.
//  6. MEM_RESP_ERROR_EN: write to 0x42.
//     -> mem_resp=1, mem_error=1; read 0x40 -> unchanged data, mem_error=0.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Word-organised memory responder for the multicycle RV32I
//               core's memory port. Serves one read or write request at a
//               time after a fixed LATENCY and pulses mem_resp on completion.
//               Optional feature macro: MEM_RESP_ERROR_EN adds the mem_error
//               port and flags misaligned or out-of-range addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp
`ifdef MEM_RESP_ERROR_EN
  ,
  output logic        mem_error
`endif
);

  localparam int          DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  LAT_M1     = 4'(LATENCY - 1);
  localparam logic [31:0] ERROR_WORD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              count;
  logic                    lat_write;
  logic [ADDR_WIDTH-1:0]   lat_idx;
  logic [31:0]             lat_wdata;
  logic [3:0]              lat_be;
  logic                    lat_err;

  logic [31:0]             store [DEPTH];

  logic                    req;
  logic [ADDR_WIDTH-1:0]   in_idx;
  logic                    in_err;
  logic                    cur_write;
  logic [ADDR_WIDTH-1:0]   cur_idx;
  logic                    cur_err;
  logic                    go_resp;
  logic                    store_we;

  assign req    = mem_read | mem_write;
  assign in_idx = mem_address[ADDR_WIDTH+1:2];

`ifdef MEM_RESP_ERROR_EN
  assign in_err = (mem_address[1:0] != 2'b00) || (|mem_address[31:ADDR_WIDTH+2]);
`else
  // Low and high address bits are deliberately ignored: the store aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_address[31:ADDR_WIDTH+2], mem_address[1:0]};
  assign in_err = 1'b0;
`endif

  // Select the live request in IDLE (LATENCY==1 completes on the sample edge), else the latched copy
  always_comb begin
    cur_write = lat_write;
    cur_idx   = lat_idx;
    cur_err   = lat_err;
    if (state == ST_IDLE) begin
      cur_write = mem_write;
      cur_idx   = in_idx;
      cur_err   = in_err;
    end
    go_resp = 1'b0;
    if ((state == ST_IDLE) && req && (LATENCY == 1)) go_resp = 1'b1;
    if ((state == ST_BUSY) && (count == 4'd1))       go_resp = 1'b1;
  end

  // Store update strobe: on the edge entering RESP for multi-cycle latency; with
  // LATENCY==1 the commit is taken from RESP so a reset there still drops it.
  always_comb begin
    store_we = 1'b0;
    if (LATENCY == 1) begin
      if (state == ST_RESP) store_we = lat_write & ~lat_err;
    end else begin
      if ((state == ST_BUSY) && (count == 4'd1)) store_we = lat_write & ~lat_err;
    end
  end

  // Control FSM with registered response, read data and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= 4'd0;
      mem_resp  <= 1'b0;
      mem_rdata <= 32'h0;
      lat_write <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= 32'h0;
      lat_be    <= 4'h0;
      lat_err   <= 1'b0;
`ifdef MEM_RESP_ERROR_EN
      mem_error <= 1'b0;
`endif
    end else begin
      mem_resp <= 1'b0;
`ifdef MEM_RESP_ERROR_EN
      mem_error <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (req) begin
            // Simultaneous read and write is treated as a write.
            lat_write <= mem_write;
            lat_idx   <= in_idx;
            lat_wdata <= mem_wdata;
            lat_be    <= mem_byte_enable;
            lat_err   <= in_err;
            count     <= LAT_M1;
            state     <= (LATENCY == 1) ? ST_RESP : ST_BUSY;
          end
        end
        ST_BUSY: begin
          count <= count - 4'd1;
          if (count == 4'd1) state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (go_resp) begin
        mem_resp <= 1'b1;
`ifdef MEM_RESP_ERROR_EN
        mem_error <= cur_err;
`endif
        if (cur_err)         mem_rdata <= ERROR_WORD;
        else if (!cur_write) mem_rdata <= store[cur_idx];
      end
    end
  end

  // Byte-lane write into the backing store (contents are never reset)
  always_ff @(posedge clk) begin
    if (store_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) store[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire
